// File: rtl/threadbrain_pkg.sv
// Shared register-file layout and fill FSM encoding for the thread-brain memory path.
package threadbrain_pkg;

  localparam int unsigned RF_ENTRY_W = 35;
  localparam int unsigned VAL_LSB    = 0;
  localparam int unsigned TAG_LSB    = 16;
  localparam int unsigned LOCKED_BIT = 32;
  localparam int unsigned RETR_BIT   = 33;
  localparam int unsigned VALID_BIT  = 34;

  typedef enum logic [1:0] {IDLE, REQ, WB, COOL} fill_state_e;

  // Index width that never collapses to zero bits.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set bit of eligible at or after ptr, wrapping.
module rr_arbiter
  import threadbrain_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]              eligible,
  input  logic [idx_width(N)-1:0]   ptr,
  output logic [idx_width(N)-1:0]   grant,
  output logic                      any_valid
);

  localparam int unsigned IW = idx_width(N);

  logic [IW-1:0] idx;

  // Walk from the farthest candidate back to ptr so the nearest eligible one wins.
  always_comb begin
    grant     = '0;
    any_valid = 1'b0;
    idx       = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr) + k) % int'(N));
      if (eligible[idx]) begin
        grant     = idx;
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_fill.sv
// Memory-fill stage: fetches locked, retrieval-pending cells and hands them to writeback.
// Optional ack watchdog enabled by defining MEM_FILL_TIMEOUT_EN.
module mem_fill
  import threadbrain_pkg::*;
#(
  parameter int unsigned NCORES  = 4,
  parameter int unsigned WB_LAT  = 2,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NCORES*RF_ENTRY_W-1:0] rf_in,
  output logic                         mem_req,
  output logic [15:0]                  mem_addr,
  input  logic                         mem_ack,
  input  logic [15:0]                  mem_rdata,
  output logic                         wb_en_out,
  output logic [15:0]                  ptr_out,
  output logic [15:0]                  val_out,
  output logic                         busy,
  output logic                         timeout_err
);

  localparam int unsigned IW = idx_width(NCORES);
  localparam int unsigned CW = idx_width(WB_LAT + 1);

  logic [NCORES-1:0] eligible;
  logic [NCORES-1:0] val_par;
  logic [15:0]       tags [NCORES];

  for (genvar i = 0; i < NCORES; i++) begin : g_entry
    localparam int unsigned Base = i * RF_ENTRY_W;
    assign eligible[i] = rf_in[Base+VALID_BIT] & rf_in[Base+RETR_BIT] & rf_in[Base+LOCKED_BIT];
    assign tags[i]     = rf_in[Base+TAG_LSB +: 16];
    assign val_par[i]  = ^rf_in[Base+VAL_LSB +: 16];
  end

  // Cached values are not needed here; writeback supplies them.
  logic unused_bits;
  assign unused_bits = ^{val_par, TIMEOUT[0]};

  logic [IW-1:0] grant;
  logic          any_valid;
  logic [IW-1:0] rr_q, rr_d;

  rr_arbiter #(
    .N (NCORES)
  ) u_arb (
    .eligible  (eligible),
    .ptr       (rr_q),
    .grant     (grant),
    .any_valid (any_valid)
  );

  fill_state_e   state_q, state_d;
  logic [CW-1:0] cool_q, cool_d;
  logic [15:0]   addr_d, ptr_d, val_d;

`ifdef MEM_FILL_TIMEOUT_EN
  localparam int unsigned TW = (idx_width(TIMEOUT + 1) > 8) ? idx_width(TIMEOUT + 1) : 8;
  logic [TW-1:0] to_q, to_d;
  logic          err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    cool_d  = cool_q;
    addr_d  = mem_addr;
    ptr_d   = ptr_out;
    val_d   = val_out;
`ifdef MEM_FILL_TIMEOUT_EN
    to_d    = to_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (any_valid) begin
          addr_d  = tags[grant];
          rr_d    = (32'(grant) == NCORES - 1) ? '0 : grant + 1'b1;
          state_d = REQ;
`ifdef MEM_FILL_TIMEOUT_EN
          to_d    = '0;
`endif
        end
      end
      REQ: begin
        if (mem_ack) begin
          val_d   = mem_rdata;
          ptr_d   = mem_addr;
          state_d = WB;
        end
`ifdef MEM_FILL_TIMEOUT_EN
        // Give up after TIMEOUT request cycles; the entry stays eligible for a retry.
        else if (to_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          cool_d  = '0;
          state_d = COOL;
        end else begin
          to_d    = to_q + 1'b1;
        end
`endif
      end
      WB: begin
        cool_d  = '0;
        state_d = COOL;
      end
      COOL: begin
        // Hold off new grants until the cleared locked bits are visible on rf_in.
        if (cool_q == CW'(WB_LAT)) begin
          state_d = IDLE;
        end else begin
          cool_d = cool_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_q     <= '0;
      cool_q   <= '0;
      mem_addr <= '0;
      ptr_out  <= '0;
      val_out  <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      cool_q   <= cool_d;
      mem_addr <= addr_d;
      ptr_out  <= ptr_d;
      val_out  <= val_d;
    end
  end

`ifdef MEM_FILL_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_q  <= '0;
      err_q <= 1'b0;
    end else begin
      to_q  <= to_d;
      err_q <= err_d;
    end
  end
  assign timeout_err = err_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign mem_req   = (state_q == REQ);
  assign wb_en_out = (state_q == WB);
  assign busy      = (state_q != IDLE);

endmodule
